// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, requests to send, shifts
// one byte plus odd parity and stop on device clock edges, then checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_ok_o,
    output logic       err_o,
    input  logic       kclk_in_i,
    input  logic       kdata_in_i,
    output logic       kclk_drive_low_o,
    output logic       kdata_drive_low_o
);
    // state     | meaning
    // IDLE      | lines released, ready for a byte
    // INHIBIT   | clock held low for INHIBIT_CYCLES
    // REQ       | clock and data low for one cycle (start bit)
    // SEND      | device clocks out frame bits; edge 11 samples the ACK (ACK_SAMPLE)
    // WAIT_IDLE | wait for both lines high, then report done or err
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // Index 0 is kclk, index 1 is kdata.
    logic [1:0]         sync1_q, sync2_q, filt_q, filt_d;
    logic [1:0][FW-1:0] fcnt_q, fcnt_d;
    logic               kclk_fall;

    logic [2:0]    state_q, state_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ack_ok_q, ack_ok_d;
    logic          kclk_dl_q, kclk_dl_d;
    logic          kdata_dl_q, kdata_dl_d;
    logic          done_w, err_w;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                    fcnt_d[i] = '0;
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end else begin
                fcnt_d[i] = '0;
            end
        end
    end

    assign kclk_fall = filt_q[0] & ~filt_d[0];

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        inh_d      = inh_q;
        tmo_d      = tmo_q;
        ack_ok_d   = ack_ok_q;
        kdata_dl_d = kdata_dl_q;
        done_w     = 1'b0;
        err_w      = 1'b0;
        case (state_q)
            S_IDLE: begin
                kdata_dl_d = 1'b0;
                if (tx_valid_i) begin
                    frame_d   = {1'b1, ~^tx_data_i, tx_data_i};
                    bit_cnt_d = 4'd0;
                    inh_d     = IW'(INHIBIT_CYCLES - 1);
                    ack_ok_d  = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_q == '0) begin
                    kdata_dl_d = 1'b1;
                    state_d    = S_REQ;
                end else begin
                    inh_d = inh_q - 1'b1;
                end
            end
            S_REQ: begin
                tmo_d   = TW'(TIMEOUT_CYCLES);
                state_d = S_SEND;
            end
            S_SEND: begin
                // A timeout outranks a clock edge arriving in the same cycle.
                if (tmo_q == '0) begin
                    err_w      = 1'b1;
                    ack_ok_d   = 1'b0;
                    kdata_dl_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                    if (kclk_fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd10) begin
                            ack_ok_d   = ~filt_q[1];
                            kdata_dl_d = 1'b0;
                            tmo_d      = TW'(TIMEOUT_CYCLES);
                            state_d    = S_WAIT;
                        end else begin
                            kdata_dl_d = ~frame_q[0];
                            frame_d    = {1'b1, frame_q[9:1]};
                        end
                    end
                end
            end
            S_WAIT: begin
                kdata_dl_d = 1'b0;
                if (tmo_q == '0) begin
                    err_w    = 1'b1;
                    ack_ok_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (filt_q == 2'b11) begin
                    done_w  = ack_ok_q;
                    err_w   = ~ack_ok_q;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            default: begin
                kdata_dl_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
        kclk_dl_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            state_q    <= S_IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            inh_q      <= '0;
            tmo_q      <= '0;
            ack_ok_q   <= 1'b0;
            kclk_dl_q  <= 1'b0;
            kdata_dl_q <= 1'b0;
        end else begin
            sync1_q    <= {kdata_in_i, kclk_in_i};
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_q      <= inh_d;
            tmo_q      <= tmo_d;
            ack_ok_q   <= ack_ok_d;
            kclk_dl_q  <= kclk_dl_d;
            kdata_dl_q <= kdata_dl_d;
        end
    end

    assign tx_ready_o        = (state_q == S_IDLE);
    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = done_w;
    assign err_o             = err_w;
    assign ack_ok_o          = ack_ok_q;
    assign kclk_drive_low_o  = kclk_dl_q;
    assign kdata_drive_low_o = kdata_dl_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames in, optionally ACKs,
// and the observed bits, pulses and timing are compared against hand-computed values.
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int TMO = 1500;
    localparam int FL  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, ack_ok, err;
    logic       kclk_dl, kdata_dl;
    logic       dev_kclk = 1'b1;
    logic       dev_kdata = 1'b1;
    logic       kclk_pin, kdata_pin;

    assign kclk_pin  = dev_kclk & ~kclk_dl;
    assign kdata_pin = dev_kdata & ~kdata_dl;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
        .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .busy_o(busy), .done_o(done), .ack_ok_o(ack_ok), .err_o(err),
        .kclk_in_i(kclk_pin), .kdata_in_i(kdata_pin),
        .kclk_drive_low_o(kclk_dl), .kdata_drive_low_o(kdata_dl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, req_cnt = 0, acc_cnt = 0;
    int done_cyc = 0, err_cyc = 0, req_cyc = 0, acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) begin err_cnt++; err_cyc = cyc; end
        if (done && err) both_cnt++;
        if (kclk_dl && !kdata_dl) inh_cnt++;
        if (kclk_dl && kdata_dl) begin req_cnt++; req_cyc = cyc; end
        if (tx_valid && tx_ready) begin acc_cnt++; acc_cyc = cyc; end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept(input logic [7:0] d);
        tick(1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < INH + 200; k++) begin
            tick(1);
            if (busy && !kclk_dl && kdata_dl) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_send", 0, 1);
    endtask

    // Device model: samples start before clocking, then one bit at each rising edge.
    task automatic bfm_frame(input bit ack, input bit glitch, output logic [10:0] got);
        bit ok;
        got = '1;
        wait_send(ok);
        if (ok) begin
            tick(10);
            got = {got[9:0], kdata_pin};
            for (int n = 1; n <= 10; n++) begin
                dev_kclk = 1'b0;
                tick(20);
                dev_kclk = 1'b1;
                got = {got[9:0], kdata_pin};
                if (glitch && n == 4) begin
                    tick(8);
                    dev_kclk = 1'b0;
                    tick(2);
                    dev_kclk = 1'b1;
                    tick(10);
                end else begin
                    tick(20);
                end
            end
            if (ack) dev_kdata = 1'b0;
            tick(20);
            dev_kclk = 1'b0;
            tick(20);
            dev_kclk = 1'b1;
            tick(5);
            dev_kdata = 1'b1;
        end
    endtask

    task automatic wait_pulse(input int d0, input int e0, input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick(1);
            if (done_cnt != d0 || err_cnt != e0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("wait_pulse", 0, 1);
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        bit          glitch;
        logic [10:0] exp_bits;
        int          exp_done;
        int          exp_err;
        int          exp_ack;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [10:0] got;
        bit seen, ok;
        int d0, e0, i0, r0, a0;

        // bits ordered start, d0..d7, parity, stop
        vecs[0] = '{8'hED, 1'b1, 1'b0, 11'b0_10110111_1_1, 1, 0, 1};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 11'b0_10000000_0_1, 1, 0, 1};
        vecs[2] = '{8'hF3, 1'b0, 1'b0, 11'b0_11001111_1_1, 0, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 11'b0_00000000_1_1, 1, 0, 1};
        vecs[4] = '{8'h6A, 1'b0, 1'b0, 11'b0_01010110_1_1, 0, 1, 0};

        tick(3);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ack_ok", ack_ok, 0);
        chk("rst_kclk_dl", kclk_dl, 0);
        chk("rst_kdata_dl", kdata_dl, 0);
        rst = 1'b0;
        tick(10);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = req_cnt;
            accept(vecs[i].data);
            bfm_frame(vecs[i].ack, vecs[i].glitch, got);
            wait_pulse(d0, e0, 300, seen);
            chk($sformatf("v%0d_bits", i), int'(got), int'(vecs[i].exp_bits));
            chk($sformatf("v%0d_inhibit", i), inh_cnt - i0, INH);
            chk($sformatf("v%0d_req", i), req_cnt - r0, 1);
            chk($sformatf("v%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            chk($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
            chk($sformatf("v%0d_ack_ok", i), ack_ok, vecs[i].exp_ack);
            chk($sformatf("v%0d_ready_after", i), tx_ready, 1);
            tick(20);
        end

        // No device clocking: timeout from the request.
        d0 = done_cnt; e0 = err_cnt;
        accept(8'hED);
        wait_pulse(d0, e0, INH + TMO + 100, seen);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_latency", err_cyc - req_cyc, TMO + 1);
        chk("tmo_kclk_rel", kclk_dl, 0);
        chk("tmo_kdata_rel", kdata_dl, 0);
        chk("tmo_ready", tx_ready, 1);
        chk("tmo_ack_ok", ack_ok, 0);
        chk("tmo_done", done_cnt - d0, 0);
        tick(20);

        // Reset mid-frame, then a clean 0xFF.
        d0 = done_cnt; e0 = err_cnt;
        accept(8'hFF);
        wait_send(ok);
        tick(10);
        for (int n = 1; n <= 4; n++) begin
            dev_kclk = 1'b0;
            tick(20);
            if (n < 4) begin
                dev_kclk = 1'b1;
                tick(20);
            end
        end
        rst = 1'b1;
        tick(1);
        chk("rst_mid_kclk", kclk_dl, 0);
        chk("rst_mid_kdata", kdata_dl, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        dev_kclk = 1'b1;
        tick(50);
        chk("rst_mid_done", done_cnt - d0, 0);
        chk("rst_mid_err", err_cnt - e0, 0);
        d0 = done_cnt; e0 = err_cnt;
        accept(8'hFF);
        bfm_frame(1'b1, 1'b0, got);
        wait_pulse(d0, e0, 300, seen);
        chk("ff_bits", int'(got), int'(11'b0_11111111_1_1));
        chk("ff_done", done_cnt - d0, 1);
        tick(20);

        // tx_valid held through a transfer with a short kclk glitch.
        d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
        tick(1);
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        tick(1);
        tx_data = 8'hF3;
        bfm_frame(1'b1, 1'b1, got);
        wait_pulse(d0, e0, 300, seen);
        chk("hold_bits1", int'(got), int'(11'b0_10000000_0_1));
        chk("hold_done1", done_cnt - d0, 1);
        chk("hold_acc_busy", acc_cnt - a0, 1);
        tick(1);
        tx_valid = 1'b0;
        chk("hold_acc2", acc_cnt - a0, 2);
        chk("hold_acc2_cyc", acc_cyc - done_cyc, 1);
        d0 = done_cnt; e0 = err_cnt;
        bfm_frame(1'b1, 1'b0, got);
        wait_pulse(d0, e0, 300, seen);
        chk("hold_bits2", int'(got), int'(11'b0_11001111_1_1));
        chk("hold_done2", done_cnt - d0, 1);
        chk("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end
endmodule
